ysyx_22050612_ifu: RTL and testbench

Instruction fetch unit directly upstream of the execute stage: holds the architectural PC, fetches one 32-bit instruction per loop from instruction memory over a valid/ready request/response handshake, and presents it with its PC to decode/execute. The next PC (`dnpc`) is accepted back from the execute stage. The block is single-issue and non-pipelined: only one fetch is in flight at any time.

---
 rtl/ysyx_22050612_ifu.sv | 137 +++++++++++++
 tb/tb_ysyx_22050612_ifu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_ifu
// Description : Single-issue, non-pipelined instruction fetch unit. Holds the
//               architectural PC, fetches one 32-bit instruction per loop over
//               a valid/ready memory handshake and buffers it for execute.
//               Optional feature macro: YSYX_22050612_IFU_ALIGN_CHK_EN
//               (misaligned-fetch trap into a sticky ERR state).
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic [63:0] dnpc,
    input  logic        dnpc_valid,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
`ifdef YSYX_22050612_IFU_ALIGN_CHK_EN
        S_EXEC  = 3'd4,
        S_ERR   = 3'd5
`else
        S_EXEC  = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic        w_capture;

    // Next-state and next-PC decode; pc only ever moves via a committed dnpc.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ready) begin
                    if (dnpc_valid) begin
                        w_pc_nxt    = dnpc;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (dnpc_valid) begin
                    w_pc_nxt    = dnpc;
                    w_state_nxt = S_REQ;
                end
            end
`ifdef YSYX_22050612_IFU_ALIGN_CHK_EN
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef YSYX_22050612_IFU_ALIGN_CHK_EN
        // Divert into ERR at the moment REQ would be entered with a
        // misaligned PC, so no request is ever raised for it.
        if ((w_state_nxt == S_REQ) && (r_state != S_REQ) &&
            (w_pc_nxt[1:0] != 2'b00)) begin
            w_state_nxt = S_ERR;
        end
`endif
    end

    // State, PC and instruction buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 32'd0;
            r_inst_pc <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_inst    <= imem_resp_data;
                r_inst_pc <= r_pc;
            end
        end
    end

    // Outputs decode purely from registered state.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_VALID);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

`ifdef YSYX_22050612_IFU_ALIGN_CHK_EN
    assign fetch_err = (r_state == S_ERR);
`else
    assign fetch_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050612_ifu
// Description : Directed self-checking bench for ysyx_22050612_ifu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] dnpc;
    logic        dnpc_valid;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    ysyx_22050612_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .dnpc            (dnpc),
        .dnpc_valid      (dnpc_valid),
        .fetch_err       (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        inst_ready      = 1'b0;
        dnpc            = 64'd0;
        dnpc_valid      = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req_valid",  {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid},     64'd0);
        chk("rst_inst",       {32'd0, inst},           64'd0);
        chk("rst_inst_pc",    inst_pc,                 64'd0);
        chk("rst_fetch_err",  {63'd0, fetch_err},      64'd0);
        chk("rst_addr",       imem_req_addr,           64'h8000_0000);

        // Release reset, memory always ready: one IDLE cycle, then REQ
        imem_req_ready = 1'b1;
        rst            = 1'b0;
        chk("idle_req_valid", {63'd0, imem_req_valid}, 64'd0);
        tick();
        chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("first_req_addr",  imem_req_addr,           64'h8000_0000);
        tick();
        chk("wait_req_valid",  {63'd0, imem_req_valid}, 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0413;
        tick();
        imem_resp_valid = 1'b0;
        chk("first_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("first_inst",       {32'd0, inst},       64'h0000_0413);
        chk("first_inst_pc",    inst_pc,             64'h8000_0000);

        // Consume with dnpc in the same cycle: straight back to REQ
        inst_ready = 1'b1;
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0004;
        tick();
        inst_ready = 1'b0;
        dnpc_valid = 1'b0;
        chk("loop_req_valid",  {63'd0, imem_req_valid}, 64'd1);
        chk("loop_req_addr",   imem_req_addr,           64'h8000_0004);
        chk("loop_inst_valid", {63'd0, inst_valid},     64'd0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        tick();
        imem_resp_valid = 1'b0;
        chk("second_inst",    {32'd0, inst}, 64'h0010_0093);
        chk("second_inst_pc", inst_pc,       64'h8000_0004);
        inst_ready = 1'b1;
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0008;
        tick();
        inst_ready = 1'b0;
        dnpc_valid = 1'b0;
        // Third REQ sits exactly 3 edges after the second REQ
        chk("steady_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("steady_req_addr",  imem_req_addr,           64'h8000_0008);

        // Memory not ready for 5 cycles; stray response during REQ ignored
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_resp_valid = (i == 2);
            imem_resp_data  = 32'hDEAD_BEEF;
            tick();
            chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("stall_req_addr",  imem_req_addr,           64'h8000_0008);
            chk("stall_inst",      {32'd0, inst},           64'h0010_0093);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        tick();
        // Now in WAIT: stray dnpc must not move pc
        dnpc_valid = 1'b1;
        dnpc       = 64'h0000_1234;
        tick();
        dnpc_valid = 1'b0;
        chk("wait_stray_addr",  imem_req_addr,           64'h8000_0008);
        chk("wait_stray_valid", {63'd0, inst_valid},     64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_0113;
        tick();
        imem_resp_valid = 1'b0;

        // Downstream back-pressure for 4 cycles; late response ignored too
        for (int i = 0; i < 4; i++) begin
            imem_resp_valid = (i == 1);
            imem_resp_data  = 32'hCAFE_F00D;
            tick();
            chk("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("bp_inst",       {32'd0, inst},       64'h0020_0113);
            chk("bp_inst_pc",    inst_pc,             64'h8000_0008);
        end
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b1;
        tick();
        inst_ready = 1'b0;
        // EXEC: nothing issued until dnpc arrives
        chk("exec_inst_valid", {63'd0, inst_valid},     64'd0);
        chk("exec_req_valid",  {63'd0, imem_req_valid}, 64'd0);
        tick();
        tick();
        chk("exec_hold_req", {63'd0, imem_req_valid}, 64'd0);
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0100;
        tick();
        dnpc_valid = 1'b0;
        chk("exec_req_valid2", {63'd0, imem_req_valid}, 64'd1);
        chk("exec_req_addr",   imem_req_addr,           64'h8000_0100);

        // Reset during WAIT, then the stale response arrives
        tick();
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h5555_AAAA;
        chk("rstw_addr",      imem_req_addr,           64'h8000_0000);
        chk("rstw_req_valid", {63'd0, imem_req_valid}, 64'd0);
        tick();
        imem_resp_valid = 1'b0;
        chk("rstw_inst_valid", {63'd0, inst_valid},     64'd0);
        chk("rstw_inst",       {32'd0, inst},           64'd0);
        chk("rstw_req_valid2", {63'd0, imem_req_valid}, 64'd1);
        chk("rstw_addr2",      imem_req_addr,           64'h8000_0000);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0030_0193;
        tick();
        imem_resp_valid = 1'b0;
        chk("rstw_inst2", {32'd0, inst}, 64'h0030_0193);

        // Misaligned dnpc
        inst_ready = 1'b1;
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0002;
        tick();
        inst_ready = 1'b0;
        dnpc_valid = 1'b0;
`ifdef YSYX_22050612_IFU_ALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            chk("err_flag",      {63'd0, fetch_err},      64'd1);
            chk("err_req_valid", {63'd0, imem_req_valid}, 64'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", {63'd0, fetch_err}, 64'd0);
        tick();
        chk("err_restart_addr", imem_req_addr, 64'h8000_0000);
`else
        chk("mis_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("mis_req_addr",  imem_req_addr,           64'h8000_0002);
        chk("mis_fetch_err", {63'd0, fetch_err},      64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
